// File: rtl/maze_pkg.sv
// Shared encodings for the memory-maze game controller: FSM states,
// move directions, difficulty levels and small arithmetic helpers.
package maze_pkg;

    typedef enum logic [2:0] {
        ST_MENU     = 3'd0,
        ST_SHOW_MAP = 3'd1,
        ST_PLAYING  = 3'd2,
        ST_FETCH    = 3'd3,
        ST_CHECK    = 3'd4,
        ST_WON      = 3'd5,
        ST_LOST     = 3'd6
    } state_e;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam logic [1:0] DIFF_EASY   = 2'd0;
    localparam logic [1:0] DIFF_MEDIUM = 2'd1;
    localparam logic [1:0] DIFF_HARD   = 2'd2;

    localparam logic [1:0] SHIFT_EASY   = 2'd0;
    localparam logic [1:0] SHIFT_MEDIUM = 2'd1;
    localparam logic [1:0] SHIFT_HARD   = 2'd2;

    // Encodings 2 and 3 are both hard.
    function automatic logic [1:0] diff_shift(input logic [1:0] diff);
        logic [1:0] sh;
        case (diff)
            DIFF_EASY:   sh = SHIFT_EASY;
            DIFF_MEDIUM: sh = SHIFT_MEDIUM;
            default:     sh = SHIFT_HARD;
        endcase
        return sh;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/maze_reveal_timer.sv
// Loadable down-counter for the map-reveal phase: load captures length-1,
// done is high while enabled and the count has reached zero.
module maze_reveal_timer #(
    parameter int LEN_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [LEN_W-1:0] length,
    output logic             done
);

    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;

    // Next-count selection: load wins over counting.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = length - LEN_W'(1);
        end else if (en && (count_q != LEN_W'(0))) begin
            count_d = count_q - LEN_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= LEN_W'(0);
        end else begin
            count_q <= count_d;
        end
    end

    assign done = en && !load && (count_q == LEN_W'(0));

endmodule

// File: rtl/maze_game_ctrl.sv
// Memory-maze game controller: reveal timer, player movement, wall checks.
// Optional feature macro MAZE_LIVES_EN adds a lives counter and lives_left port.
module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter int GRID_W      = 30,
    parameter int GRID_H      = 21,
    parameter int SHOW_CYCLES = 1000000,
    parameter int LIVES       = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [1:0]                  difficulty,
    input  logic                        move_valid,
    input  logic [1:0]                  move_dir,
    output logic                        move_ready,
    output logic [$clog2(GRID_H)-1:0]   rom_addr,
    input  logic [GRID_W-1:0]           rom_data,
    output logic [$clog2(GRID_W)-1:0]   player_x,
    output logic [$clog2(GRID_H)-1:0]   player_y,
    output logic                        map_visible,
    output logic [2:0]                  game_state,
    output logic                        lost,
    output logic                        won,
    output logic [15:0]                 move_count
`ifdef MAZE_LIVES_EN
    ,
    output logic [$clog2(LIVES+1)-1:0]  lives_left
`endif
);

    localparam int XW    = $clog2(GRID_W);
    localparam int AW    = $clog2(GRID_H);
    localparam int LEN_W = $clog2(SHOW_CYCLES + 1);
    localparam logic [LEN_W-1:0] SHOW_LEN = LEN_W'(SHOW_CYCLES);
    localparam logic [XW-1:0]    X_MAX    = XW'(GRID_W - 1);
    localparam logic [AW-1:0]    Y_MAX    = AW'(GRID_H - 1);

    state_e          state_q, state_d;
    logic [XW-1:0]   px_q, px_d, tx_q, tx_d;
    logic [AW-1:0]   py_q, py_d, ty_q, ty_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic            lost_q, lost_d, won_q, won_d;
    logic            move_ready_q, move_ready_d;
    logic            map_visible_q, map_visible_d;
    logic [15:0]     mc_q, mc_d;
    logic [1:0]      diff_q, diff_d;
    logic            timer_load_s, timer_done_s;
    logic [LEN_W-1:0] reveal_len_s;
    logic [XW-1:0]   tgt_x_s;
    logic [AW-1:0]   tgt_y_s;
    logic            oob_s;
`ifdef MAZE_LIVES_EN
    localparam int LW = $clog2(LIVES + 1);
    logic [LW-1:0]   lives_q, lives_d;
`endif

    // Target cell of the requested move and whether it leaves the grid.
    always_comb begin
        tgt_x_s = px_q;
        tgt_y_s = py_q;
        oob_s   = 1'b0;
        case (move_dir)
            DIR_LEFT: begin
                if (px_q == XW'(0)) oob_s = 1'b1;
                else                tgt_x_s = px_q - XW'(1);
            end
            DIR_RIGHT: begin
                if (px_q == X_MAX) oob_s = 1'b1;
                else               tgt_x_s = px_q + XW'(1);
            end
            DIR_UP: begin
                if (py_q == AW'(0)) oob_s = 1'b1;
                else                tgt_y_s = py_q - AW'(1);
            end
            default: begin
                if (py_q == Y_MAX) oob_s = 1'b1;
                else               tgt_y_s = py_q + AW'(1);
            end
        endcase
    end

    // Main FSM: next state and next values of all game registers.
    always_comb begin
        state_d      = state_q;
        px_d         = px_q;
        py_d         = py_q;
        tx_d         = tx_q;
        ty_d         = ty_q;
        rom_addr_d   = rom_addr_q;
        lost_d       = lost_q;
        won_d        = won_q;
        mc_d         = mc_q;
        diff_d       = diff_q;
        timer_load_s = 1'b0;
`ifdef MAZE_LIVES_EN
        lives_d      = lives_q;
`endif
        case (state_q)
            ST_MENU, ST_WON, ST_LOST: begin
                if (start) begin
                    diff_d       = difficulty;
                    px_d         = XW'(0);
                    py_d         = AW'(0);
                    lost_d       = 1'b0;
                    won_d        = 1'b0;
                    mc_d         = 16'd0;
                    timer_load_s = 1'b1;
`ifdef MAZE_LIVES_EN
                    lives_d      = LW'(LIVES);
`endif
                    state_d      = ST_SHOW_MAP;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SHOW_MAP: begin
                if (timer_done_s) state_d = ST_PLAYING;
                else              state_d = ST_SHOW_MAP;
            end
            ST_PLAYING: begin
                if (move_valid && move_ready_q && !oob_s) begin
                    tx_d       = tgt_x_s;
                    ty_d       = tgt_y_s;
                    rom_addr_d = tgt_y_s;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_PLAYING;
                end
            end
            ST_FETCH: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (rom_data[tx_q]) begin
`ifdef MAZE_LIVES_EN
                    lives_d = lives_q - LW'(1);
                    mc_d    = sat_inc16(mc_q);
                    if (lives_q <= LW'(1)) begin
                        lost_d  = 1'b1;
                        state_d = ST_LOST;
                    end else begin
                        state_d = ST_PLAYING;
                    end
`else
                    lost_d  = 1'b1;
                    state_d = ST_LOST;
`endif
                end else begin
                    px_d = tx_q;
                    py_d = ty_q;
                    mc_d = sat_inc16(mc_q);
                    if ((tx_q == X_MAX) && (ty_q == Y_MAX)) begin
                        won_d   = 1'b1;
                        state_d = ST_WON;
                    end else begin
                        state_d = ST_PLAYING;
                    end
                end
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase

        // Status flags are registered from the next state so they line up with game_state.
        move_ready_d  = (state_d == ST_PLAYING);
        map_visible_d = (state_d == ST_SHOW_MAP) || (state_d == ST_WON) ||
                        (state_d == ST_LOST);
    end

    assign reveal_len_s = SHOW_LEN >> diff_shift(diff_d);

    maze_reveal_timer #(
        .LEN_W (LEN_W)
    ) u_reveal_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load_s),
        .en     (state_q == ST_SHOW_MAP),
        .length (reveal_len_s),
        .done   (timer_done_s)
    );

    // Game state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_MENU;
            px_q          <= XW'(0);
            py_q          <= AW'(0);
            tx_q          <= XW'(0);
            ty_q          <= AW'(0);
            rom_addr_q    <= AW'(0);
            lost_q        <= 1'b0;
            won_q         <= 1'b0;
            mc_q          <= 16'd0;
            diff_q        <= 2'd0;
            move_ready_q  <= 1'b0;
            map_visible_q <= 1'b0;
`ifdef MAZE_LIVES_EN
            lives_q       <= LW'(0);
`endif
        end else begin
            state_q       <= state_d;
            px_q          <= px_d;
            py_q          <= py_d;
            tx_q          <= tx_d;
            ty_q          <= ty_d;
            rom_addr_q    <= rom_addr_d;
            lost_q        <= lost_d;
            won_q         <= won_d;
            mc_q          <= mc_d;
            diff_q        <= diff_d;
            move_ready_q  <= move_ready_d;
            map_visible_q <= map_visible_d;
`ifdef MAZE_LIVES_EN
            lives_q       <= lives_d;
`endif
        end
    end

    assign move_ready  = move_ready_q;
    assign rom_addr    = rom_addr_q;
    assign player_x    = px_q;
    assign player_y    = py_q;
    assign map_visible = map_visible_q;
    assign game_state  = state_q;
    assign lost        = lost_q;
    assign won         = won_q;
    assign move_count  = mc_q;
`ifdef MAZE_LIVES_EN
    assign lives_left  = lives_q;
`endif

endmodule
